// File: rtl/exception_ctrl_if.sv
// Pipeline/CP0 side bundle for the exception initiator: MEM-stage inputs, CP0 state in,
// exception commit and flush/redirect out.
interface exception_ctrl_if;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [31:0] mem_addr_i;
  logic [7:0]  exc_flags_i;
  logic        eret_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i;
  logic        data_busy_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_o;

  modport slave (
    input  mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_addr_i, exc_flags_i, eret_i,
           status_i, cause_i, epc_i, cp0_we_i, cp0_waddr_i, cp0_wdata_i, data_busy_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, flush_o,
           new_pc_o, stall_o
  );

  modport master (
    output mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_addr_i, exc_flags_i, eret_i,
           status_i, cause_i, epc_i, cp0_we_i, cp0_waddr_i, cp0_wdata_i, data_busy_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, flush_o,
           new_pc_o, stall_o
  );
endinterface

// File: rtl/exception_ctrl.sv
// MEM/WB exception initiator: prioritises interrupts and exception flags, waits for the
// data SRAM to go idle, then issues a single-cycle commit + flush to CP0.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input logic             clk,
  input logic             rst,
  exception_ctrl_if.slave bus
);
  localparam logic [31:0] C_INT  = 32'h1;
  localparam logic [31:0] C_ADEL = 32'h4;
  localparam logic [31:0] C_ADES = 32'h5;
  localparam logic [31:0] C_SYS  = 32'h8;
  localparam logic [31:0] C_BP   = 32'h9;
  localparam logic [31:0] C_RI   = 32'ha;
  localparam logic [31:0] C_OV   = 32'hc;
  localparam logic [31:0] C_TR   = 32'hd;
  localparam logic [31:0] C_ERET = 32'he;

  typedef enum logic [1:0] {IDLE, DRAIN, EMIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic        ds_q, ds_d;
  logic [31:0] bad_q, bad_d;
  logic [31:0] target_q, target_d;

  logic        int_req;
  logic        capture;
  logic [31:0] code_sel, bad_sel, target_sel;

  // Bits of Status/Cause outside IE/EXL/IM/IP carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus.status_i[31:16], bus.status_i[7:2], bus.cause_i[31:16], bus.cause_i[7:0]};

  always_comb begin
    int_req  = bus.status_i[0] & ~bus.status_i[1] & (|(bus.cause_i[15:8] & bus.status_i[15:8]));
    code_sel = '0;
    bad_sel  = '0;
    if (int_req)                  code_sel = C_INT;
    else if (bus.exc_flags_i[0]) begin code_sel = C_ADEL; bad_sel = bus.mem_pc_i; end
    else if (bus.exc_flags_i[1])  code_sel = C_RI;
    else if (bus.exc_flags_i[2])  code_sel = C_OV;
    else if (bus.exc_flags_i[3])  code_sel = C_TR;
    else if (bus.exc_flags_i[4])  code_sel = C_SYS;
    else if (bus.exc_flags_i[5])  code_sel = C_BP;
    else if (bus.exc_flags_i[6]) begin code_sel = C_ADEL; bad_sel = bus.mem_addr_i; end
    else if (bus.exc_flags_i[7]) begin code_sel = C_ADES; bad_sel = bus.mem_addr_i; end
    else if (bus.eret_i)          code_sel = C_ERET;

    // ERET returns to EPC, taking an MTC0 EPC write landing this same cycle into account.
    target_sel = EXC_VECTOR;
    if (code_sel == C_ERET)
      target_sel = (bus.cp0_we_i && bus.cp0_waddr_i == 5'd14) ? bus.cp0_wdata_i : bus.epc_i;

    capture = (state_q == IDLE) && bus.mem_valid_i && (code_sel != '0);
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    pc_d     = pc_q;
    ds_d     = ds_q;
    bad_d    = bad_q;
    target_d = target_q;
    unique case (state_q)
      IDLE: if (capture) begin
        state_d  = bus.data_busy_i ? DRAIN : EMIT;
        code_d   = code_sel;
        pc_d     = bus.mem_pc_i;
        ds_d     = bus.mem_in_delayslot_i;
        bad_d    = bad_sel;
        target_d = target_sel;
      end
      DRAIN:   if (!bus.data_busy_i) state_d = EMIT;
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      code_q   <= '0;
      pc_q     <= '0;
      ds_q     <= 1'b0;
      bad_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      pc_q     <= pc_d;
      ds_q     <= ds_d;
      bad_q    <= bad_d;
      target_q <= target_d;
    end
  end

  // Outputs are gated by state so reset zeroes them without waiting for a clock.
  always_comb begin
    bus.excepttype_o        = '0;
    bus.current_inst_addr_o = '0;
    bus.is_in_delayslot_o   = 1'b0;
    bus.bad_addr_o          = '0;
    bus.flush_o             = 1'b0;
    bus.new_pc_o            = '0;
    bus.stall_o             = (state_q == DRAIN);
    if (state_q == EMIT) begin
      bus.excepttype_o        = code_q;
      bus.current_inst_addr_o = pc_q;
      bus.is_in_delayslot_o   = ds_q;
      bus.bad_addr_o          = bad_q;
      bus.flush_o             = 1'b1;
      bus.new_pc_o            = target_q;
    end
  end
endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Exception initiator for the MIPS pipeline; it sits at the MEM/WB boundary and drives the CP0 register block. It collects per-instruction exception flags and pending interrupts, prioritises them, and waits for any in-flight data-SRAM access to drain. It then issues a one-cycle exception commit (type code, faulting PC, delay-slot flag, bad address) to CP0 together with a pipeline flush and redirect PC.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for all exceptions other than ERET

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- mem_valid_i  in  1  instruction in MEM stage is valid
- mem_pc_i  in  32  PC of the MEM-stage instruction
- mem_in_delayslot_i  in  1  instruction is in a branch delay slot
- mem_addr_i  in  32  data address of load/store
- exc_flags_i  in  8  bit0 adel_if, 1 ri, 2 ov, 3 trap, 4 syscall, 5 break, 6 adel_ld, 7 ades
- eret_i  in  1  instruction is ERET
- status_i  in  32  CP0 Status
- cause_i  in  32  CP0 Cause
- epc_i  in  32  CP0 EPC
- cp0_we_i, cp0_waddr_i(5), cp0_wdata_i(32)  in  MTC0 write currently presented to CP0, used for EPC bypass
- data_busy_i  in  1  data-SRAM transaction outstanding
- excepttype_o  out  32  exception code to CP0: 1 int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, a RI, c Ov, d Tr, e ERET; 0 otherwise
- current_inst_addr_o  out  32  faulting PC
- is_in_delayslot_o  out  1  delay-slot flag of the faulting instruction
- bad_addr_o  out  32  BadVAddr value
- flush_o  out  1  flush all pipeline stages
- new_pc_o  out  32  redirect PC, valid while flush_o=1
- stall_o  out  1  freeze pipeline while an exception is being drained

## Operation
- Interrupt request: int_req = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]). It is evaluated every cycle and attaches only to a valid MEM instruction.
- Priority, highest first: int (1), adel_if (4), ri (a), ov (c), trap (d), syscall (8), break (9), adel_ld (4), ades (5), eret (e).
- bad_addr: adel_if uses mem_pc_i; adel_ld and ades use mem_addr_i; all other types give 0.
- Redirect target: EXC_VECTOR for every type except ERET. For ERET the target is epc_i, or cp0_wdata_i when cp0_we_i=1 and cp0_waddr_i=14 in the capture cycle.
- Capture happens when mem_valid_i=1, a cause is present, and state is IDLE. It latches the code, PC, delay-slot flag, bad address and target.
- State machine:
  - IDLE -> EMIT when capture occurs and data_busy_i=0.
  - IDLE -> DRAIN when capture occurs and data_busy_i=1.
  - DRAIN -> EMIT on the first cycle with data_busy_i=0.
  - EMIT -> IDLE unconditionally.
- stall_o is 1 in DRAIN. In EMIT, excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o, new_pc_o and flush_o=1 are driven from the latched values. All of these outputs are 0 in IDLE and DRAIN.
- mem_valid_i and the flags are ignored in DRAIN and EMIT.
- A fresh capture is allowed in the IDLE cycle immediately after EMIT.

## Timing
- Reset values: state IDLE; every output 0; all capture registers 0.
- Latency: capture in cycle T with no busy -> EMIT outputs in T+1, exactly one cycle wide.
- Capture in T with busy -> DRAIN from T+1. If busy drops in cycle D, EMIT occurs in D+1.
- Interrupt and synchronous exception in the same cycle: the interrupt wins. The PC and delay-slot flag are still those of the MEM instruction, and bad_addr is 0.
- Delay slot: current_inst_addr_o carries mem_pc_i unmodified; the PC-4 adjustment is done by CP0.
- rst asserted in any state forces IDLE and zero outputs immediately, and no pending EMIT is issued.

## Test plan
- Syscall at PC 0x1000, delayslot=0, busy=0 -> next cycle excepttype_o=8, current_inst_addr_o=0x1000, flush_o=1, new_pc_o=0xBFC00380 for one cycle only.
- Load adel_ld, addr 0x0000_0003, PC 0x2000, delayslot=1 -> excepttype_o=4, bad_addr_o=0x3, is_in_delayslot_o=1.
- Store ades with busy=1 for 3 cycles -> stall_o=1 for 3 cycles, then EMIT with excepttype_o=5; flush_o stays 0 during drain.
- status=0x0000_0401, cause[10]=1, ri flag set, PC 0x3000 -> excepttype_o=1 (interrupt beats RI). Repeating with status[1]=1 -> excepttype_o=a.
- ERET with epc_i=0x4000, while cp0_we_i=1 waddr=14 wdata=0x5000 in the same cycle -> new_pc_o=0x5000, excepttype_o=e.
- rst pulsed while in DRAIN -> all outputs 0 asynchronously; no EMIT after busy drops.
